tq_pp_ram: RTL and testbench
============================

TQ_PP_RAM -- requirements
Module: tq_pp_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 128, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, per-bank address width (depth 2**ADDR_W).
REQ-003 SHALL have parameter LANE_W, default 16, write-mask granularity; DATA_W SHALL be a multiple of LANE_W, and NL = DATA_W/LANE_W.
REQ-004 SHALL have ports:
  clk       in   1          single clock, rising edge
  rst       in   1          reset, synchronous, active-high
  wr_en     in   1          write strobe
  wr_addr   in   ADDR_W     write address in the current write bank
  wr_data   in   DATA_W     write data
  wr_mask   in   NL         lane enable; bit i covers bits [i*LANE_W +: LANE_W]
  wr_done   in   1          commit the current write bank
  wr_rdy    out  1          a free bank is available
  rd_en     in   1          read strobe
  rd_addr   in   ADDR_W     read address in the current read bank
  rd_done   in   1          release the current read bank
  rd_rdy    out  1          a committed bank is available
  rd_data   out  DATA_W     read data
  rd_vld    out  1          rd_data is valid this cycle
  full_cnt  out  2          number of committed banks, 0..2

Function
REQ-005 SHALL hold two banks (ping-pong), each 2**ADDR_W x DATA_W.
REQ-006 SHALL keep internal wbank, rbank (1 bit each) and full_cnt.
- wr_rdy = (full_cnt < 2)
- rd_rdy = (full_cnt > 0)
REQ-007 wr_en && wr_rdy SHALL write lanes with wr_mask[i]=1 at wr_addr of wbank. Unmasked lanes SHALL be unchanged.
REQ-008 wr_en while !wr_rdy SHALL be ignored, with no memory change.
REQ-009 wr_done && wr_rdy SHALL toggle wbank and increment full_cnt. wr_done while !wr_rdy SHALL be ignored.
REQ-010 wr_en and wr_done in the same cycle: the write SHALL land in the pre-toggle bank.
REQ-011 rd_en && rd_rdy SHALL read rd_addr of rbank. rd_data SHALL be valid with rd_vld=1 exactly 1 cycle later (base latency 1).
REQ-012 rd_en while !rd_rdy SHALL be ignored, with rd_vld=0 for that slot.
REQ-013 rd_done && rd_rdy SHALL toggle rbank and decrement full_cnt. rd_done while !rd_rdy SHALL be ignored.
REQ-014 rd_en and rd_done in the same cycle: the read SHALL use the pre-toggle bank.
REQ-015 Effective wr_done and rd_done in the same cycle SHALL toggle both pointers and leave full_cnt unchanged.
REQ-016 rd_data SHALL hold its last value when no read completes.
REQ-017 Simultaneous read and write to the same bank cannot occur while full_cnt is 1; at full_cnt=0 reads are blocked. No read-during-write forwarding is required.

Reset
REQ-018 On rst=1 at a clock edge: full_cnt=0, wbank=0, rbank=0, rd_vld=0, rd_data=0, wr_rdy=1, rd_rdy=0.
REQ-019 Memory contents SHALL NOT be reset.
REQ-020 Reset mid-operation SHALL discard committed banks and suppress any in-flight read: rd_vld=0 in the cycle after reset.
REQ-021 Inputs asserted during reset SHALL be ignored.

Configuration
REQ-022 Macro TQ_RAM_OUTREG_EN, when defined, SHALL add an output register stage:
- read latency 2
- rd_vld delayed in step with the data
- extra stage cleared by rst
REQ-023 Without TQ_RAM_OUTREG_EN, read latency SHALL be 1 per REQ-011.

Structure
REQ-024 A shared package tq_ram_pkg SHALL hold the default DATA_W/ADDR_W/LANE_W constants and the bank-count constant 2.
REQ-025 Storage SHALL be one sub-module, tq_ram_2p_core: a dual-port, lane-masked RF with depth 2**(ADDR_W+1), addressed {bank, addr}, 1-cycle read. Pointer and count control SHALL stay in tq_pp_ram.

Verification
REQ-026 Benches SHALL cover the following directed scenarios (defaults unless noted):
- Fill/drain: write addr 0..31 = index, wr_done, then read 0..31. Expect rd_data = index at latency 1, full_cnt 0->1->0.
- Mask: write 0xFF..FF at addr 3, then wr_mask=0x0001 with 0x0 data. Expect read = 0xFFFF..FFFF_0000.
- Full: two wr_done with no reads. Expect full_cnt=2, wr_rdy=0; a third wr_en to addr 0 is ignored, and bank 0 data is intact on read.
- Simultaneous: at full_cnt=1, assert wr_done and rd_done together. Expect full_cnt stays 1 and both pointers toggle.
- Empty/reset: rd_en at full_cnt=0 gives rd_vld=0. Assert rst one cycle after a valid rd_en: rd_vld=0 and full_cnt=0 next cycle.
- With TQ_RAM_OUTREG_EN: the fill/drain scenario SHALL show latency 2.

Source files
------------

// File: rtl/tq_ram_pkg.sv
// -----------------------------------------------------------------------------
// tq_ram_pkg
// Shared constants for the ping-pong lane-masked RAM (tq_pp_ram) and its
// storage core (tq_ram_2p_core).
//   TQ_DATA_W    default word width in bits
//   TQ_ADDR_W    default per-bank address width (bank depth 2**TQ_ADDR_W)
//   TQ_LANE_W    default write-mask lane width in bits
//   TQ_NUM_BANKS number of ping-pong banks (fixed at 2)
// Helper:
//   tq_next_cnt  committed-bank count after a commit and/or release
// -----------------------------------------------------------------------------
package tq_ram_pkg;

  localparam int TQ_DATA_W    = 128;
  localparam int TQ_ADDR_W    = 5;
  localparam int TQ_LANE_W    = 16;
  localparam int TQ_NUM_BANKS = 2;

  // A commit and a release in the same cycle cancel out; the count never
  // leaves 0..2 because both events are qualified by wr_rdy / rd_rdy.
  function automatic logic [1:0] tq_next_cnt(input logic [1:0] cnt,
                                             input logic       commit,
                                             input logic       release_bank);
    logic [1:0] nxt;
    nxt = cnt;
    if (commit && !release_bank) nxt = cnt + 2'd1;
    if (!commit && release_bank) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/tq_ram_2p_core.sv
// -----------------------------------------------------------------------------
// tq_ram_2p_core
// Dual-port (one write, one read) register-file storage with per-lane write
// enables and a registered read port (1-cycle read latency).
// The array itself is never reset; only the read output register is.
// Ports:
//   clk    in   1        clock, rising edge
//   rst    in   1        synchronous active-high reset (read register only)
//   we     in   1        write enable
//   waddr  in   AW       write address
//   wdata  in   DATA_W   write data
//   wmask  in   NL       lane enables, bit i covers [i*LANE_W +: LANE_W]
//   re     in   1        read enable
//   raddr  in   AW       read address
//   rdata  out  DATA_W   read data, updated one cycle after re, else held
// -----------------------------------------------------------------------------
module tq_ram_2p_core #(
  parameter int DATA_W = 128,
  parameter int AW     = 6,
  parameter int LANE_W = 16,
  localparam int NL    = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NL-1:0]     wmask,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Lane-masked write; lanes with a clear mask bit keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NL; i++) begin
        if (wmask[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tq_pp_ram.sv
// -----------------------------------------------------------------------------
// tq_pp_ram
// Two-bank ping-pong buffer with lane-masked writes. The writer fills the
// current write bank and commits it with wr_done; the reader reads the oldest
// committed bank and releases it with rd_done. full_cnt counts committed banks.
// Optional build macro:
//   TQ_RAM_OUTREG_EN  adds an output register stage (read latency 2 instead
//                     of 1); rd_vld is delayed in step with rd_data.
// Ports:
//   clk       in   1        clock, rising edge
//   rst       in   1        synchronous active-high reset
//   wr_en     in   1        write strobe
//   wr_addr   in   ADDR_W   write address in current write bank
//   wr_data   in   DATA_W   write data
//   wr_mask   in   NL       lane enables (bit i covers [i*LANE_W +: LANE_W])
//   wr_done   in   1        commit current write bank
//   wr_rdy    out  1        a free bank is available
//   rd_en     in   1        read strobe
//   rd_addr   in   ADDR_W   read address in current read bank
//   rd_done   in   1        release current read bank
//   rd_rdy    out  1        a committed bank is available
//   rd_data   out  DATA_W   read data (held when no read completes)
//   rd_vld    out  1        rd_data valid this cycle
//   full_cnt  out  2        number of committed banks, 0..2
// Handshake: a write/commit takes effect only on a cycle where wr_rdy is high,
// a read/release only where rd_rdy is high; strobes on other cycles, or while
// rst is high, are dropped with no side effect. DATA_W must be a multiple of
// LANE_W.
// -----------------------------------------------------------------------------
module tq_pp_ram
  import tq_ram_pkg::*;
#(
  parameter int DATA_W = TQ_DATA_W,
  parameter int ADDR_W = TQ_ADDR_W,
  parameter int LANE_W = TQ_LANE_W,
  localparam int NL    = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NL-1:0]     wr_mask,
  input  logic              wr_done,
  output logic              wr_rdy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_rdy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  output logic [1:0]        full_cnt
);

  logic       wbank;
  logic       rbank;
  logic [1:0] cnt;

  logic wr_fire;
  logic rd_fire;
  logic commit;
  logic release_bank;

  logic              rd_vld_s1;
  logic [DATA_W-1:0] core_rdata;

  assign wr_rdy   = (cnt < 2'd2);
  assign rd_rdy   = (cnt != 2'd0);
  assign full_cnt = cnt;

  // Gate with rst so nothing issued during reset reaches the array.
  assign wr_fire      = wr_en   && wr_rdy && !rst;
  assign rd_fire      = rd_en   && rd_rdy && !rst;
  assign commit       = wr_done && wr_rdy;
  assign release_bank = rd_done && rd_rdy;

  // Pointer/count update. Reads and writes in the same cycle as a toggle
  // use the pre-toggle bank because the core sees the registered pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      cnt   <= 2'd0;
    end else begin
      if (commit)       wbank <= ~wbank;
      if (release_bank) rbank <= ~rbank;
      cnt <= tq_next_cnt(cnt, commit, release_bank);
    end
  end

  tq_ram_2p_core #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1),
    .LANE_W (LANE_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_fire),
    .waddr ({wbank, wr_addr}),
    .wdata (wr_data),
    .wmask (wr_mask),
    .re    (rd_fire),
    .raddr ({rbank, rd_addr}),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) rd_vld_s1 <= 1'b0;
    else     rd_vld_s1 <= rd_fire;
  end

`ifdef TQ_RAM_OUTREG_EN
  // Second stage loads only when the first stage carries a completed read,
  // so rd_data still holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= rd_vld_s1;
      if (rd_vld_s1) rd_data <= core_rdata;
    end
  end
`else
  assign rd_data = core_rdata;
  assign rd_vld  = rd_vld_s1;
`endif

endmodule

// File: tb/tb_tq_pp_ram.sv
// -----------------------------------------------------------------------------
// tb_tq_pp_ram
// Self-checking bench for tq_pp_ram: directed scenarios followed by random
// traffic, with a bank-level reference model and an expected-read queue that
// a separate monitor drains whenever a response is due.
// -----------------------------------------------------------------------------
module tb_tq_pp_ram;
  import tq_ram_pkg::*;

  localparam int DATA_W = TQ_DATA_W;
  localparam int ADDR_W = TQ_ADDR_W;
  localparam int LANE_W = TQ_LANE_W;
  localparam int NL     = DATA_W / LANE_W;
  localparam int DEPTH  = 2**ADDR_W;
`ifdef TQ_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [NL-1:0]     wr_mask = '0;
  logic              wr_done = 1'b0;
  logic              wr_rdy;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_done = 1'b0;
  logic              rd_rdy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;
  logic [1:0]        full_cnt;

  tq_pp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .wr_done  (wr_done),
    .wr_rdy   (wr_rdy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_done  (rd_done),
    .rd_rdy   (rd_rdy),
    .rd_data  (rd_data),
    .rd_vld   (rd_vld),
    .full_cnt (full_cnt)
  );

  // Number of rising edges seen so far; stable when sampled on the falling edge.
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, ecnt, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Two banks of words, a write bank, a read bank and a committed-bank count.
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  bit                m_wb = 1'b0;
  bit                m_rb = 1'b0;
  int                m_cnt = 0;

  // Expected output events: a read result, or a reset marker (rd_vld=0, rd_data=0).
  typedef struct {
    logic              mark;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t exp_q[$];

  task automatic check_status();
    chk("full_cnt", DATA_W'(full_cnt), DATA_W'(m_cnt));
    chk("wr_rdy",   DATA_W'(wr_rdy),   DATA_W'(m_cnt < 2));
    chk("rd_rdy",   DATA_W'(rd_rdy),   DATA_W'(m_cnt > 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic we, input logic [ADDR_W-1:0] wa,
                     input logic [DATA_W-1:0] wd, input logic [NL-1:0] wm,
                     input logic wdn, input logic re,
                     input logic [ADDR_W-1:0] ra, input logic rdn);
    bit wrdy;
    bit rrdy;
    rst = 1'b0;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm; wr_done = wdn;
    rd_en = re; rd_addr = ra; rd_done = rdn;
    wrdy = (m_cnt < 2);
    rrdy = (m_cnt > 0);
    if (re && rrdy) exp_q.push_back('{1'b0, m_mem[m_rb][ra], ecnt + LAT});
    if (we && wrdy) begin
      for (int i = 0; i < NL; i++)
        if (wm[i]) m_mem[m_wb][wa][i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
    end
    if (wdn && wrdy) begin m_wb = ~m_wb; m_cnt = m_cnt + 1; end
    if (rdn && rrdy) begin m_rb = ~m_rb; m_cnt = m_cnt - 1; end
    @(negedge clk);
    check_status();
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [NL-1:0] m,
                    input logic dn);
    cyc(1'b1, ADDR_W'(a), d, m, dn, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input int a, input logic dn);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, ADDR_W'(a), dn);
  endtask

  // One reset cycle with junk on every input; none of it may take effect.
  task automatic rst_cyc();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = ADDR_W'($urandom()); wr_data = rnd_word();
    wr_mask = '1; wr_done = 1'b1;
    rd_en = 1'b1; rd_addr = ADDR_W'($urandom()); rd_done = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].due > ecnt) void'(exp_q.pop_back());
    exp_q.push_back('{1'b1, '0, ecnt + 1});
    m_wb = 1'b0; m_rb = 1'b0; m_cnt = 0;
    @(negedge clk);
    check_status();
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // ---------------- monitor ----------------
  logic [DATA_W-1:0] held;
  initial begin
    exp_t e;
    logic exp_v;
    held = '0;
    forever begin
      @(negedge clk);
      exp_v = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == ecnt) begin
        e = exp_q.pop_front();
        if (e.mark) held = '0;
        else begin
          exp_v = 1'b1;
          held  = e.data;
        end
      end
      chk("rd_vld",  DATA_W'(rd_vld), DATA_W'(exp_v));
      chk("rd_data", rd_data, held);
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [NL-1:0] ALL = '1;

  initial begin
    logic [DATA_W-1:0] ones;
    ones = '1;

    // Reset state (inputs asserted during reset must be ignored)
    rst_cyc();
    rst_cyc();
    idle();
    chk("reset_rd_data", rd_data, '0);

    // Fill/drain bank 0 with address-valued data
    for (int i = 0; i < DEPTH; i++) wr(i, DATA_W'(i), ALL, 1'b0);
    wr(0, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) rd(i, 1'b0);
    rd(0, 1'b1);

    // Fill/drain bank 1 with random data so both banks are initialised
    for (int i = 0; i < DEPTH; i++) wr(i, rnd_word(), ALL, 1'b0);
    wr(0, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) rd(i, 1'b0);
    rd(0, 1'b1);

    // Lane mask: only lane 0 cleared; read together with rd_done
    wr(3, ones, ALL, 1'b0);
    wr(3, '0, NL'(1), 1'b1);
    rd(2, 1'b0);
    rd(3, 1'b1);
    chk("mask_model", m_mem[0][3], {ones[DATA_W-1:LANE_W], {LANE_W{1'b0}}});

    // Full: two commits, third write and commit ignored
    wr(0, rnd_word(), ALL, 1'b1);
    wr(5, rnd_word(), ALL, 1'b1);
    wr(0, rnd_word(), ALL, 1'b1);
    wr(5, rnd_word(), ALL, 1'b0);
    rd(0, 1'b0);
    rd(0, 1'b1);

    // Simultaneous commit+release at full_cnt=1, with write and read in the
    // same cycle landing in the pre-toggle banks
    cyc(1'b1, ADDR_W'(7), rnd_word(), ALL, 1'b1, 1'b1, ADDR_W'(5), 1'b1);
    rd(7, 1'b0);
    rd(5, 1'b1);

    // Empty read, then reset one cycle after a valid read
    rd(4, 1'b0);
    wr(2, rnd_word(), ALL, 1'b1);
    rd(2, 1'b0);
    rst_cyc();
    idle();
    idle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if (n == 300) rst_cyc();
      else cyc(1'($urandom_range(0, 1)), ADDR_W'($urandom()), rnd_word(),
               NL'($urandom()), ($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 1)), ADDR_W'($urandom()),
               ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 4; i++) idle();
    chk("exp_q_drained", DATA_W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
